// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder/loader:
// request kinds, ALU codes, RV32I opcode fields, halt word.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    K_R_ALU = 3'd0,
    K_I_ALU = 3'd1,
    K_LW    = 3'd2,
    K_SW    = 3'd3,
    K_BEQ   = 3'd4
  } kind_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // beq x0,x0,0 : spins in place
  localparam logic [31:0] HALT_WORD = 32'h0000_0063;

endpackage

// File: rtl/rv_encode.sv
// Combinational encoder: symbolic request -> RV32I word
// plus a legality flag.
module rv_encode
  import instr_enc_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  alu_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       alu_ok;
  logic       is_sub;

  // Map the ALU code onto funct3/funct7
  always_comb begin
    f3     = F3_ADD;
    f7     = F7_BASE;
    alu_ok = 1'b1;
    is_sub = 1'b0;
    unique case (alu_i)
      ALU_ADD: f3 = F3_ADD;
      ALU_SUB: begin
        f7     = F7_SUB;
        is_sub = 1'b1;
      end
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_SLT: f3 = F3_SLT;
      default: alu_ok = 1'b0;
    endcase
  end

  // Pack fields per instruction format
  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    unique case (1'b1)
      kind_i == K_R_ALU: begin
        word_o  = {f7, rs2_i, rs1_i,
                   f3, rd_i, OP_R};
        legal_o = alu_ok;
      end
      kind_i == K_I_ALU: begin
        word_o  = {imm_i[11:0], rs1_i,
                   f3, rd_i, OP_I};
        legal_o = alu_ok && !is_sub;
      end
      kind_i == K_LW: begin
        word_o  = {imm_i[11:0], rs1_i,
                   F3_W, rd_i, OP_LW};
        legal_o = 1'b1;
      end
      kind_i == K_SW: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i,
                   F3_W, imm_i[4:0], OP_SW};
        legal_o = 1'b1;
      end
      kind_i == K_BEQ: begin
        word_o  = {imm_i[12], imm_i[10:5],
                   rs2_i, rs1_i, F3_BEQ,
                   imm_i[4:1], imm_i[11], OP_BEQ};
        legal_o = !imm_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes micro-op requests and streams them into imem.
// Optional halt-word append: define INSTR_ENC_HALT_EN.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned          DEPTH     = 64,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  localparam int unsigned         CW = $clog2(DEPTH+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_kind_i,
  input  logic [2:0]        req_alu_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [12:0]       req_imm_i,
  input  logic              finish_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              err_o,
  output logic              full_o,
  output logic [CW-1:0]     count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FULL
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CW-1:0]     count_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              err_q;
  logic              full_q;
  logic              halt_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        idle_ok;
  logic        accept;
  logic        halt_go;

  rv_encode u_enc (
    .kind_i  (req_kind_i),
    .alu_i   (req_alu_i),
    .rd_i    (req_rd_i),
    .rs1_i   (req_rs1_i),
    .rs2_i   (req_rs2_i),
    .imm_i   (req_imm_i),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  assign idle_ok = (state_q == S_IDLE)
                && !full_q && !clear_i;

`ifdef INSTR_ENC_HALT_EN
  assign halt_go     = idle_ok && finish_i;
  assign req_ready_o = idle_ok && !finish_i;
`else
  logic unused_finish;
  assign unused_finish = finish_i;
  assign halt_go       = 1'b0;
  assign req_ready_o   = idle_ok;
`endif

  assign accept = req_valid_i && req_ready_o;
  assign addr_d = addr_q + ADDR_W'(4);

  // Loader FSM: accept, write for one cycle, advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          we_q  <= 1'b0;
          err_q <= 1'b0;
          if (halt_go) begin
            wdata_q <= HALT_WORD;
            we_q    <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= S_WRITE;
          end else if (accept) begin
            if (enc_legal) wdata_q <= enc_word;
            we_q    <= enc_legal;
            err_q   <= !enc_legal;
            halt_q  <= 1'b0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          we_q  <= 1'b0;
          err_q <= 1'b0;
          if (we_q) begin
            addr_q  <= addr_d;
            count_q <= count_q + 1'b1;
          end
          if (we_q && (halt_q || count_q == LAST)) begin
            full_q  <= 1'b1;
            state_q <= S_FULL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FULL: full_q <= 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we_o    = we_q && !clear_i && !rst_i;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign full_o      = full_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised bench for instr_encoder_loader against a
// transaction-level reference model.
module tb_instr_encoder_loader;

  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  kind = '0;
  logic [2:0]  alu = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [12:0] imm = '0;
  logic        finish = 1'b0;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        err;
  logic        full;
  logic [3:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  instr_encoder_loader #(
    .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_kind_i(kind), .req_alu_i(alu),
    .req_rd_i(rd), .req_rs1_i(rs1), .req_rs2_i(rs2),
    .req_imm_i(imm), .finish_i(finish),
    .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .err_o(err),
    .full_o(full), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference encoder built from field arithmetic
  function automatic void ref_enc(
      input int unsigned k, input int unsigned a,
      input int unsigned d, input int unsigned s1,
      input int unsigned s2, input int unsigned im,
      output logic [31:0] w, output bit ok);
    int unsigned f3, f7, r;
    bit aok;
    f3 = 0; f7 = 0; aok = 1; r = 0; ok = 0;
    case (a)
      0: f3 = 0;
      1: begin f3 = 0; f7 = 32; end
      2: f3 = 7;
      3: f3 = 6;
      5: f3 = 2;
      default: aok = 0;
    endcase
    case (k)
      0: begin
        ok = aok;
        r = 'h33 + (d << 7) + (f3 << 12) + (s1 << 15)
          + (s2 << 20) + (f7 << 25);
      end
      1: begin
        ok = aok && (a != 1);
        r = 'h13 + (d << 7) + (f3 << 12) + (s1 << 15)
          + ((im & 'hFFF) << 20);
      end
      2: begin
        ok = 1;
        r = 'h03 + (d << 7) + (2 << 12) + (s1 << 15)
          + ((im & 'hFFF) << 20);
      end
      3: begin
        ok = 1;
        r = 'h23 + ((im & 'h1F) << 7) + (2 << 12)
          + (s1 << 15) + (s2 << 20)
          + (((im >> 5) & 'h7F) << 25);
      end
      4: begin
        ok = (im & 1) == 0;
        r = 'h63 + (((im >> 11) & 1) << 7)
          + (((im >> 1) & 'hF) << 8)
          + (s1 << 15) + (s2 << 20)
          + (((im >> 5) & 'h3F) << 25)
          + (((im >> 12) & 1) << 31);
      end
      default: ok = 0;
    endcase
    w = r;
  endfunction

  // Model state
  bit          m_busy = 0;
  bit          m_we = 0;
  bit          m_err = 0;
  bit          m_full = 0;
  bit          m_halt = 0;
  int          m_count = 0;
  logic [31:0] m_addr = BASE;
  logic [31:0] m_wdata = '0;

  // Advance the model on each clock edge
  always @(posedge clk) begin
    logic [31:0] w;
    bit ok;
    if (rst) begin
      m_busy = 0; m_we = 0; m_err = 0; m_full = 0;
      m_halt = 0; m_count = 0; m_addr = BASE;
      m_wdata = '0;
    end else if (clear) begin
      m_busy = 0; m_we = 0; m_err = 0; m_full = 0;
      m_halt = 0; m_count = 0; m_addr = BASE;
    end else if (m_busy) begin
      if (m_we) begin
        m_addr = m_addr + 4;
        m_count++;
        if (m_count == DEPTH || m_halt) m_full = 1;
      end
      m_busy = 0; m_we = 0; m_err = 0;
    end else if (!m_full) begin
`ifdef INSTR_ENC_HALT_EN
      if (finish) begin
        m_busy = 1; m_we = 1; m_halt = 1;
        m_wdata = 32'h0000_0063;
      end else
`endif
      if (valid) begin
        ref_enc(kind, alu, rd, rs1, rs2, imm, w, ok);
        m_busy = 1; m_halt = 0;
        m_we = ok; m_err = !ok;
        if (ok) m_wdata = w;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !m_busy && !m_full && !clear;
`ifdef INSTR_ENC_HALT_EN
    exp_rdy = exp_rdy && !finish;
`endif
    chk("req_ready", 32'(ready), 32'(exp_rdy));
    chk("mem_we", 32'(we),
        32'(m_we && !clear && !rst));
    chk("mem_addr", addr, m_addr);
    chk("err", 32'(err), 32'(m_err));
    chk("full", 32'(full), 32'(m_full));
    chk("count", 32'(count), 32'(m_count));
    if (m_we) chk("mem_wdata", wdata, m_wdata);
    else if (rst === 1'b0 && m_count == 0 && !m_full)
      chk("mem_wdata_idle", wdata, m_wdata);
  end

  task automatic issue(input int k, input int a,
                       input int d, input int s1,
                       input int s2, input int im);
    kind = 3'(k); alu = 3'(a); rd = 5'(d);
    rs1 = 5'(s1); rs2 = 5'(s2); imm = 13'(im);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] w;
    bit ok;
    // Pin the reference encoder to hand-encoded words
    ref_enc(0, 0, 3, 1, 2, 0, w, ok);
    chk("lit_add", w, 32'h002081B3);
    chk("lit_add_ok", 32'(ok), 32'd1);
    ref_enc(0, 1, 5, 6, 7, 0, w, ok);
    chk("lit_sub", w, 32'h407302B3);
    ref_enc(2, 0, 4, 2, 0, 8, w, ok);
    chk("lit_lw", w, 32'h00812203);
    ref_enc(3, 6, 0, 2, 4, 12, w, ok);
    chk("lit_sw", w, 32'h00412623);
    ref_enc(4, 0, 0, 1, 2, 'h1FF8, w, ok);
    chk("lit_beq", w, 32'hFE208CE3);
    chk("lit_beq_ok", 32'(ok), 32'd1);
    ref_enc(4, 0, 0, 1, 2, 'h1FF9, w, ok);
    chk("lit_beq_odd", 32'(ok), 32'd0);
    ref_enc(1, 1, 1, 1, 0, 5, w, ok);
    chk("lit_isub", 32'(ok), 32'd0);
    ref_enc(5, 0, 1, 1, 1, 0, w, ok);
    chk("lit_kind5", 32'(ok), 32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed program from the test plan
    issue(0, 0, 3, 1, 2, 0);
    issue(0, 1, 5, 6, 7, 0);
    issue(2, 7, 4, 2, 0, 8);
    issue(3, 7, 0, 2, 4, 12);
    issue(4, 0, 0, 1, 2, 'h1FF8);
    issue(4, 0, 0, 1, 2, 'h1FF9);
    issue(1, 1, 9, 9, 0, 3);
    issue(1, 2, 9, 9, 0, 3);
    issue(1, 4, 9, 9, 0, 3);
    issue(0, 5, 1, 2, 3, 0);
    issue(0, 3, 1, 2, 3, 0);
    issue(2, 0, 1, 2, 3, 4);
    issue(3, 0, 1, 2, 3, 4);
    repeat (2) @(posedge clk); #1;
    clear = 1'b1;
    valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    valid = 1'b0;
    issue(0, 0, 3, 1, 2, 0);
    // Reset landing on a WRITE cycle
    kind = 3'd2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      clear  = ($urandom_range(0, 39) == 0);
      finish = ($urandom_range(0, 19) == 0);
      valid  = ($urandom_range(0, 9) < 7);
      kind   = ($urandom_range(0, 9) == 0)
             ? 3'($urandom_range(5, 7))
             : 3'($urandom_range(0, 4));
      alu    = 3'($urandom_range(0, 7));
      rd     = 5'($urandom_range(0, 31));
      rs1    = 5'($urandom_range(0, 31));
      rs2    = 5'($urandom_range(0, 31));
      imm    = 13'($urandom_range(0, 8191));
      @(posedge clk); #1;
    end
    rst = 1'b0; clear = 1'b0;
    valid = 1'b0; finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's control/instruction decode path.
- Accepts symbolic micro-op requests (kind, ALU operation, registers, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I instruction word and writes it sequentially into instruction memory.
- Used as the bench/boot program loader feeding the single-cycle core's instruction memory.

Parameters:
- DEPTH, 64, maximum number of instruction words written before the block reports full
- ADDR_W, 32, width of the byte address driven to instruction memory
- BASE_ADDR, 0, byte address of the first written word

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous restart of address/count; lower priority than rst
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_kind  in  3  0=R_ALU, 1=I_ALU, 2=LW, 3=SW, 4=BEQ; 5-7 illegal
- req_alu  in  3  ALU code: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_imm  in  13  signed immediate; [11:0] for I/LW/SW, [12:0] for BEQ
- finish  in  1  append halt word (optional feature)
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  byte address of the word being written
- mem_wdata  out  32  encoded instruction
- err  out  1  one-cycle pulse: previous accepted request was illegal
- full  out  1  DEPTH words written
- count  out  $clog2(DEPTH+1)  words written so far

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, full=0, count=0.
- FSM states: IDLE, WRITE, FULL.
- req_ready = (state==IDLE) && !full && !clear.
- IDLE:
  - On req_valid && req_ready at cycle N, latch the encoded word and the legality flag, then go to WRITE.
  - Legal request: mem_we=1 for exactly cycle N+1, with mem_wdata and mem_addr stable.
  - Illegal request: err=1 for cycle N+1, mem_we=0, address and count unchanged.
- WRITE (cycle N+1): then addr+=4 and count+=1 when written. If count reaches DEPTH, go to FULL; otherwise return to IDLE. Peak throughput is one word per 2 cycles.
- FULL: full=1, req_ready=0. Stays here until rst or clear.
- clear:
  - Returns to IDLE with addr=BASE_ADDR and count=0.
  - clear during WRITE abandons the write (mem_we forced 0).
  - clear in the same cycle as req_valid: request not accepted.
- rst overrides clear and all other inputs.
- Opcodes: R 0110011, I 0010011, LW 0000011 (funct3 010), SW 0100011 (funct3 010), BEQ 1100011 (funct3 000).
- ALU mapping (funct3 / funct7): add 000/0000000, sub 000/0100000 (R only), and 111, or 110, slt 010.
- Immediate packing:
  - I/LW: imm[11:0] into bits 31:20.
  - SW: imm[11:5] into 31:25, imm[4:0] into 11:7.
  - BEQ: imm[12|10:5] into 31:25, imm[4:1|11] into 11:7.
- Illegal requests:
  - req_kind>=5.
  - Undefined req_alu code with R_ALU or I_ALU.
  - I_ALU with sub.
  - BEQ with req_imm[0]=1.
- req_alu is ignored for LW, SW and BEQ.
- Address wraps modulo 2^ADDR_W; no error is raised on wrap.

Optional Feature:
- Macro: INSTR_ENC_HALT_EN.
- Enabled: finish sampled high in IDLE (not full, no same-cycle acceptance; finish has priority over req_valid) writes halt word 0x00000063 (beq x0,x0,0) at the next address, increments count, then enters FULL regardless of count.
- Disabled: finish port present but ignored; no halt word written.

Decomposition:
- Package instr_enc_pkg holds:
  - kind enum values
  - ALU code constants (shared with the ALU decoder encoding)
  - opcode/funct3/funct7 localparams
  - HALT_WORD constant
- One combinational sub-module, rv_encode: request fields in, 32-bit word and legal flag out.
- FSM, counter and handshake live in the top module.

Test Plan:
- add x3,x1,x2 (kind 0, alu 000) accepted at cycle N -> mem_we=1 at N+1, mem_addr=0x0, mem_wdata=0x002081B3, count=1.
- Back-to-back requests:
  - sub x5,x6,x7 -> word 0x407302B3 at 0x0.
  - lw x4,8(x2) -> word 0x00812203 at 0x4.
  - sw x4,12(x2) -> word 0x00412623 at 0x8.
  - req_ready low in each WRITE cycle.
- beq x1,x2,-8 (req_imm=13'h1FF8) -> 0xFE208CE3. Same with req_imm=13'h1FF9 -> err pulse, mem_we=0, count unchanged.
- I_ALU with alu=001 -> err=1 one cycle, no write; next legal request is written at the unchanged address.
- DEPTH=4: four legal writes -> full=1, req_ready=0, fifth req_valid ignored. Then clear -> count=0, next write at BASE_ADDR.
- rst asserted during WRITE -> mem_we=0 that cycle, all outputs at reset values next cycle. With INSTR_ENC_HALT_EN: finish after 2 words -> 0x00000063 at 0x8, full=1.
